// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer: register map, TCON layout,
// and the word-offset decode helper.
package timer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PSC_W  = 28;

  localparam logic [3:0] OFF_TH   = 4'h0;
  localparam logic [3:0] OFF_TL   = 4'h4;
  localparam logic [3:0] OFF_TCON = 4'h8;
  localparam logic [3:0] OFF_PSC  = 4'hC;

  localparam int unsigned TCON_EN   = 0;
  localparam int unsigned TCON_IEN  = 1;
  localparam int unsigned TCON_STAT = 2;

  typedef enum logic [1:0] {
    REG_TH   = 2'd0,
    REG_TL   = 2'd1,
    REG_TCON = 2'd2,
    REG_PSC  = 2'd3
  } reg_e;

  // Bit order matches the TCON layout: stat[2], ien[1], en[0].
  typedef struct packed {
    logic stat;
    logic ien;
    logic en;
  } tcon_t;

  // Map address bits [3:2] onto a register selector.
  function automatic reg_e reg_decode(input logic [1:0] word);
    reg_e r;
    r = REG_TH;
    case ({word, 2'b00})
      OFF_TH:   r = REG_TH;
      OFF_TL:   r = REG_TL;
      OFF_TCON: r = REG_TCON;
      OFF_PSC:  r = REG_PSC;
      default:  r = REG_TH;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// CPU data-bus view of a memory-mapped peripheral: byte address, write data,
// strobes and combinational read data.
interface timer_ctrl_if;
  import timer_pkg::*;

  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              mem_write;
  logic              mem_read;

  modport master (output addr, wdata, mem_write, mem_read, input rdata);
  modport slave  (input addr, wdata, mem_write, mem_read, output rdata);
endinterface

// File: rtl/tick_prescaler.sv
// Programmable enable-pulse generator: one tick every psc+1 enabled cycles.
// Reusable for any sysclk-derived rate (timer, UART, display scan).
module tick_prescaler #(
  parameter int unsigned PSC_W = timer_pkg::PSC_W
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             en,
  input  logic [PSC_W-1:0] psc,
  input  logic             psc_load,
  output logic             tick
);

  logic [PSC_W-1:0] pcnt;
  logic             at_term;

  assign at_term = (pcnt == psc);
  // A terminal reload restarts the period, so that edge never ticks.
  assign tick    = en & at_term & ~psc_load;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (psc_load) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= at_term ? '0 : pcnt + PSC_W'(1);
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Memory-mapped timer: programmable prescaler driving a reloadable 32-bit
// up-counter that flags overflow and raises a level interrupt.
module timer_ctrl #(
  parameter logic [31:0]      BASE_ADDR = 32'h4000_0000,
  parameter int unsigned      PSC_W     = timer_pkg::PSC_W,
  parameter logic [PSC_W-1:0] PSC_RESET = PSC_W'(32'd6_249_999)
) (
  input  logic         sysclk,
  input  logic         reset,
  timer_ctrl_if.slave  bus,
  output logic         tick_out,
  output logic         irq
);
  import timer_pkg::*;

  logic [DATA_W-1:0] th;
  logic [DATA_W-1:0] tl;
  tcon_t             tcon;
  logic [PSC_W-1:0]  psc;

  logic sel;
  reg_e rsel;
  logic wr_any;
  logic wr_th;
  logic wr_tl;
  logic wr_tcon;
  logic wr_psc;
  logic tick;
  logic tl_max;
  logic ovf;
  logic unused_addr_lsb;

  // Byte lane bits are irrelevant for word-only registers.
  assign unused_addr_lsb = ^bus.addr[1:0];

  assign sel     = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign rsel    = reg_decode(bus.addr[3:2]);
  assign wr_any  = bus.mem_write & sel;
  assign wr_th   = wr_any & (rsel == REG_TH);
  assign wr_tl   = wr_any & (rsel == REG_TL);
  assign wr_tcon = wr_any & (rsel == REG_TCON);
  assign wr_psc  = wr_any & (rsel == REG_PSC);

  tick_prescaler #(
    .PSC_W (PSC_W)
  ) u_prescaler (
    .sysclk   (sysclk),
    .reset    (reset),
    .en       (tcon.en),
    .psc      (psc),
    .psc_load (wr_psc),
    .tick     (tick)
  );

  assign tick_out = tick;

  // A CPU write to TL swallows the tick, including any overflow it would cause.
  assign tl_max = (tl == '1);
  assign ovf    = tick & tl_max & ~wr_tl;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      th <= '0;
    end else if (wr_th) begin
      th <= bus.wdata;
    end
  end

  // Wrap reloads from TH (pre-write value if TH is written on the same edge).
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      tl <= '0;
    end else if (wr_tl) begin
      tl <= bus.wdata;
    end else if (tick) begin
      tl <= tl_max ? th : tl + DATA_W'(1);
    end
  end

  // Overflow setting stat wins over a simultaneous write-1-to-clear.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      tcon <= '0;
    end else begin
      if (wr_tcon) begin
        tcon.en  <= bus.wdata[TCON_EN];
        tcon.ien <= bus.wdata[TCON_IEN];
      end
      if (ovf) begin
        tcon.stat <= 1'b1;
      end else if (wr_tcon && bus.wdata[TCON_STAT]) begin
        tcon.stat <= 1'b0;
      end
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      psc <= PSC_RESET;
    end else if (wr_psc) begin
      psc <= bus.wdata[PSC_W-1:0];
    end
  end

  assign irq = tcon.stat & tcon.ien;

  // Zero-wait-state read mux; idle bus reads as zero.
  always_comb begin
    bus.rdata = '0;
    if (bus.mem_read && sel) begin
      case (rsel)
        REG_TH:   bus.rdata = th;
        REG_TL:   bus.rdata = tl;
        REG_TCON: bus.rdata = {29'h0, tcon};
        REG_PSC:  bus.rdata = DATA_W'(psc);
        default:  bus.rdata = '0;
      endcase
    end
  end

endmodule
